// File: rtl/joypad_poller.sv
// Periodic joypad poller: drives a controller bridge handshake, latches the
// button snapshot and queues per-button press/release events in a show-ahead FIFO.
module joypad_poller #(
  parameter int unsigned POLL_PERIOD = 833333,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       bridge_start,
  output logic [1:0] bridge_addr,
  input  logic [7:0] bridge_rdata,
  output logic [7:0] buttons,
  output logic       buttons_valid,
  output logic       evt_valid,
  output logic [7:0] evt_data,
  input  logic       evt_pop,
  output logic       evt_overflow,
  input  logic       clr_overflow
);

  localparam int unsigned TW = $clog2(POLL_PERIOD);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, CHK_READY, START, WAIT_BUSY, WAIT_DONE, CHK_VALID, LATCH, EMIT
  } state_t;

  state_t      state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic        pending_q, pending_d;
  logic [7:0]  buttons_q, buttons_d;
  logic        bvalid_q, bvalid_d;
  logic [7:0]  diff_q, diff_d;
  logic [2:0]  idx_q, idx_d;
  logic        push;
  logic [7:0]  push_data;
  logic        expire;

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] count_q, count_d;
  logic        ovf_q, ovf_d;
  logic        empty, full, do_push, do_pop;

  assign expire = enable && (timer_q == TW'(POLL_PERIOD - 1));

  always_comb begin
    timer_d = timer_q;
    if (!enable || expire) timer_d = '0;
    else                   timer_d = timer_q + TW'(1);
  end

  // An expiry while a request is already pending is dropped, so a pending
  // request can only ever be consumed by IDLE here.
  always_comb begin
    pending_d = pending_q;
    if (!enable)        pending_d = 1'b0;
    else if (pending_q) pending_d = (state_q != IDLE);
    else                pending_d = expire;
  end

  always_comb begin
    state_d      = state_q;
    bridge_start = 1'b0;
    bridge_addr  = 2'b00;
    buttons_d    = buttons_q;
    bvalid_d     = bvalid_q;
    diff_d       = diff_q;
    idx_d        = idx_q;
    push         = 1'b0;
    push_data    = '0;
    unique case (state_q)
      IDLE:      if (pending_q) state_d = CHK_READY;
      CHK_READY: if (bridge_rdata[0]) state_d = START;
      START: begin
        bridge_start = 1'b1;
        state_d      = WAIT_BUSY;
      end
      WAIT_BUSY: if (!bridge_rdata[0]) state_d = WAIT_DONE;
      WAIT_DONE: if (bridge_rdata[0]) state_d = CHK_VALID;
      CHK_VALID: begin
        bridge_addr = 2'b01;
        state_d     = bridge_rdata[0] ? LATCH : IDLE;
      end
      LATCH: begin
        bridge_addr = 2'b10;
        diff_d      = bridge_rdata ^ buttons_q;
        buttons_d   = bridge_rdata;
        bvalid_d    = 1'b1;
        idx_d       = '0;
        state_d     = EMIT;
      end
      EMIT: begin
        push      = diff_q[idx_q];
        push_data = {buttons_q[idx_q], 4'b0000, idx_q};
        idx_d     = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = evt_pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = do_pop  ? rd_q + AW'(1) : rd_q;
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
    ovf_d = ovf_q;
    if (push && !do_push)  ovf_d = 1'b1;
    else if (clr_overflow) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      pending_q <= 1'b0;
      buttons_q <= '0;
      bvalid_q  <= 1'b0;
      diff_q    <= '0;
      idx_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      buttons_q <= buttons_d;
      bvalid_q  <= bvalid_d;
      diff_q    <= diff_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset: contents are only visible while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_q] <= push_data;
  end

  assign buttons       = buttons_q;
  assign buttons_valid = bvalid_q;
  assign evt_valid     = !empty;
  assign evt_data      = empty ? '0 : mem_q[rd_q];
  assign evt_overflow  = ovf_q;

endmodule

// File: tb/tb_joypad_poller.sv
// Directed bench for joypad_poller with a behavioural controller bridge.
module tb_joypad_poller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       evt_pop = 1'b0;
  logic       clr_overflow = 1'b0;
  logic       bridge_start;
  logic [1:0] bridge_addr;
  logic [7:0] bridge_rdata;
  logic [7:0] buttons;
  logic       buttons_valid;
  logic       evt_valid;
  logic [7:0] evt_data;
  logic       evt_overflow;

  logic [7:0] joy = 8'h00;
  logic       jvalid = 1'b1;
  logic [2:0] bcnt;
  int unsigned cyc = 0;
  int unsigned n_pass = 0;
  int unsigned n_chk = 0;

  joypad_poller #(.POLL_PERIOD(100), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .bridge_start(bridge_start), .bridge_addr(bridge_addr), .bridge_rdata(bridge_rdata),
    .buttons(buttons), .buttons_valid(buttons_valid),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_pop(evt_pop),
    .evt_overflow(evt_overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bridge: busy for 4 cycles after a start, ready otherwise; shares rst.
  always @(posedge clk) begin
    if (rst)               bcnt <= 3'd0;
    else if (bridge_start) bcnt <= 3'd4;
    else if (bcnt != 3'd0) bcnt <= bcnt - 3'd1;
  end

  always_comb begin
    bridge_rdata = joy;
    if (bridge_addr == 2'b00)      bridge_rdata = {7'b0, bcnt == 3'd0};
    else if (bridge_addr == 2'b01) bridge_rdata = {7'b0, jvalid};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_start"}, bridge_start, 1'b0);
    chk({pfx, "_addr"}, bridge_addr, 2'b00);
    chk({pfx, "_buttons"}, buttons, 8'h00);
    chk({pfx, "_bvalid"}, buttons_valid, 1'b0);
    chk({pfx, "_evt_valid"}, evt_valid, 1'b0);
    chk({pfx, "_evt_data"}, evt_data, 8'h00);
    chk({pfx, "_ovf"}, evt_overflow, 1'b0);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, evt_valid, 1'b1);
    chk(tag, evt_data, exp);
    evt_pop = 1'b1;
    tick();
    evt_pop = 1'b0;
  endtask

  task automatic wait_start(output int unsigned at);
    int n = 0;
    while (bridge_start !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("start_seen", bridge_start, 1'b1);
    at = cyc;
  endtask

  task automatic wait_latch();
    int n = 0;
    while (bridge_addr !== 2'b10 && n < 60) begin
      tick();
      n++;
    end
    chk("latch_seen", bridge_addr, 2'b10);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned rel, s1, s2;

    enable = 1'b1;
    joy    = 8'h05;
    repeat (3) tick();
    chk_reset_outs("rst0");
    rst = 1'b0;
    rel = cyc;

    // First poll: 05h from 00h -> presses of buttons 0 and 2.
    wait_start(s1);
    chk("first_start_cycle", (s1 - rel >= 100) && (s1 - rel <= 102), 1'b1);
    chk("start_addr", bridge_addr, 2'b00);
    tick();
    chk("start_one_cycle", bridge_start, 1'b0);
    repeat (25) tick();
    chk("p1_buttons", buttons, 8'h05);
    chk("p1_bvalid", buttons_valid, 1'b1);
    pop_chk("p1_e0", 8'h80);
    pop_chk("p1_e1", 8'h82);
    chk("p1_empty", evt_valid, 1'b0);
    chk("p1_empty_data", evt_data, 8'h00);

    // Second poll: 04h -> release of button 0 only.
    joy = 8'h04;
    wait_start(s1);
    repeat (25) tick();
    chk("p2_buttons", buttons, 8'h04);
    pop_chk("p2_e0", 8'h00);
    chk("p2_empty", evt_valid, 1'b0);

    // Invalid snapshot: nothing changes; period unaffected.
    jvalid = 1'b0;
    joy    = 8'hFF;
    wait_start(s1);
    repeat (25) tick();
    chk("p3_buttons", buttons, 8'h04);
    chk("p3_no_evt", evt_valid, 1'b0);
    jvalid = 1'b1;
    joy    = 8'h00;
    wait_start(s2);
    chk("p4_period", s2 - s1, 100);
    repeat (25) tick();
    chk("p4_buttons", buttons, 8'h00);
    pop_chk("p4_e0", 8'h02);
    chk("p4_empty", evt_valid, 1'b0);

    // Overflow: FFh fills the FIFO, 00h releases are all dropped.
    joy = 8'hFF;
    wait_start(s1);
    repeat (25) tick();
    chk("full_no_ovf", evt_overflow, 1'b0);
    joy = 8'h00;
    wait_start(s1);
    repeat (25) tick();
    chk("ovf_set", evt_overflow, 1'b1);
    chk("ovf_buttons", buttons, 8'h00);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("ovf_clr", evt_overflow, 1'b0);
    for (int i = 0; i < 8; i++) pop_chk($sformatf("ovf_e%0d", i), 8'h80 + 8'(i));
    chk("ovf_empty", evt_valid, 1'b0);

    // Full FIFO with pop held across the whole EMIT: every push accepted.
    joy = 8'hFF;
    wait_start(s1);
    repeat (25) tick();
    joy = 8'h00;
    wait_start(s1);
    wait_latch();
    tick();
    evt_pop = 1'b1;
    repeat (8) tick();
    evt_pop = 1'b0;
    repeat (3) tick();
    chk("pp_no_ovf", evt_overflow, 1'b0);
    for (int i = 0; i < 8; i++) pop_chk($sformatf("pp_e%0d", i), 8'(i));
    chk("pp_empty", evt_valid, 1'b0);

    // Reset during EMIT index 3, then re-poll diffs against 00h.
    joy = 8'hA5;
    wait_start(s1);
    wait_latch();
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk_reset_outs("rst1");
    rst = 1'b0;
    rel = cyc;
    wait_start(s1);
    chk("rst_start_cycle", (s1 - rel >= 100) && (s1 - rel <= 102), 1'b1);
    repeat (25) tick();
    chk("r_buttons", buttons, 8'hA5);
    pop_chk("r_e0", 8'h80);
    pop_chk("r_e1", 8'h82);
    pop_chk("r_e2", 8'h85);
    pop_chk("r_e3", 8'h87);
    chk("r_empty", evt_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/joypad_poller.md
JOYPAD_POLLER -- requirements
Module: joypad_poller

Interface
REQ-001 The block SHALL have parameter POLL_PERIOD, default 833333, meaning clock cycles between poll requests (60 Hz at 50 MHz); legal values are 4 and above.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, meaning event FIFO entries; legal values are powers of 2 and at least 2.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 enable  in  1  1 = periodic polling runs; 0 = timer held at 0 and no new polls start.
REQ-006 bridge_start  out  1  one-cycle start pulse to the controller bridge.
REQ-007 bridge_addr  out  2  bridge read select: 00 = ready, 01 = joypad_valid, 1x = joypad; combinational from FSM state.
REQ-008 bridge_rdata  in  8  bridge read data; combinational response to bridge_addr in the same cycle.
REQ-009 buttons  out  8  last successfully latched joypad snapshot.
REQ-010 buttons_valid  out  1  set after the first successful latch.
REQ-011 evt_valid  out  1  event FIFO not empty.
REQ-012 evt_data  out  8  FIFO head, show-ahead: [7] = 1 press / 0 release, [2:0] = button index, [6:3] = 0; all zeros when empty.
REQ-013 evt_pop  in  1  consume head when evt_valid = 1.
REQ-014 evt_overflow  out  1  sticky flag: an event was dropped.
REQ-015 clr_overflow  in  1  clears evt_overflow.

Function
REQ-016 The timer SHALL count 0..POLL_PERIOD-1 while enable = 1; at POLL_PERIOD-1 it SHALL wrap to 0 and set poll_pending.
REQ-017 At most one poll request SHALL be pending; expiries while poll_pending = 1 are dropped.
REQ-018 When enable = 0, the timer SHALL be held at 0, poll_pending SHALL be cleared, and a poll already in progress SHALL complete.
REQ-019 The FSM SHALL have states IDLE, CHK_READY, START, WAIT_BUSY, WAIT_DONE, CHK_VALID, LATCH and EMIT.
REQ-020 IDLE: bridge_addr = 00; if poll_pending = 1, clear poll_pending and go to CHK_READY.
REQ-021 CHK_READY: bridge_addr = 00; if bridge_rdata[0] = 1, go to START; otherwise stay.
REQ-022 START: bridge_start = 1 for exactly this one cycle; go to WAIT_BUSY.
REQ-023 WAIT_BUSY: bridge_addr = 00; on bridge_rdata[0] = 0, go to WAIT_DONE.
REQ-024 WAIT_DONE: bridge_addr = 00; on bridge_rdata[0] = 1, go to CHK_VALID.
REQ-025 CHK_VALID: bridge_addr = 01; if bridge_rdata[0] = 1, go to LATCH; otherwise go to IDLE with buttons unchanged and no events.
REQ-026 LATCH: bridge_addr = 10; capture new = bridge_rdata, diff = new XOR buttons, buttons <= new, buttons_valid <= 1; bit index <= 0; go to EMIT.
REQ-027 EMIT: takes exactly 8 cycles, index 0..7 ascending; if diff[index] = 1, push event {new[index], 0000, index[2:0]}; after index 7, go to IDLE.
REQ-028 Events from one poll SHALL enter the FIFO in ascending button-index order.
REQ-029 bridge_start SHALL be 0 in every state except START.
REQ-030 FIFO pop SHALL occur only when evt_pop = 1 and evt_valid = 1; a pop when empty is ignored.
REQ-031 Push and pop in the same cycle SHALL both take effect, including when the FIFO is full; occupancy is unchanged.
REQ-032 A push when full without a pop SHALL drop the new event and set evt_overflow.
REQ-033 If clr_overflow = 1 coincides with a drop, evt_overflow SHALL end set.
REQ-034 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy 0..FIFO_DEPTH SHALL be distinguishable.
REQ-035 evt_data SHALL update in the cycle after a push to an empty FIFO (one-cycle push-to-visible latency).

Reset
REQ-036 While rst = 1, the block SHALL set: FSM to IDLE, timer = 0, poll_pending = 0, bridge_start = 0, bridge_addr = 00, buttons = 00h, buttons_valid = 0, FIFO emptied, evt_valid = 0, evt_data = 00h, evt_overflow = 0.
REQ-037 Reset asserted mid-poll or mid-EMIT SHALL abort with no further pushes; the first post-reset poll diffs against 00h.
REQ-038 The integrator SHALL drive the bridge reset from the same rst (bridge rst_n = ~rst).

Verification (POLL_PERIOD = 100, FIFO_DEPTH = 8, behavioural bridge model)
REQ-039 Reset release with enable = 1 and bridge joypad = 05h -> first bridge_start in cycle 100; after EMIT, buttons = 05h, events 80h then 82h, evt_valid = 1.
REQ-040 Second poll with joypad = 04h -> exactly one event 00h (button 0 released); buttons = 04h.
REQ-041 Bridge reports joypad_valid = 0 -> buttons unchanged, no events, FSM returns to IDLE, next poll is 100 cycles after the previous expiry.
REQ-042 No pops; joypad alternates FFh / 00h over 2 polls (16 events) -> FIFO holds the first 8 (80h..87h), evt_overflow = 1; clr_overflow -> 0.
REQ-043 FIFO full with evt_pop held through an EMIT push -> occupancy stays 8, no overflow, order preserved.
REQ-044 rst asserted during EMIT index 3 -> all outputs at reset values the next cycle; FIFO empty; the next poll re-emits presses for all held buttons.
